// File: rtl/bus32_arb_if.sv
// Request/grant bundle between the bus sources, the arbiter and the 74x244 bus block.
// The arbiter connects through the master modport; the bus block and sources use slave.
interface bus32_arb_if #(
    parameter int N = 8
);
    localparam int OW = $clog2(N);

    logic [N-1:0]  req;    // per-source request, active-high
    logic [N-1:0]  gnt;    // one-hot grant, active-high
    logic [N-1:0]  g;      // buffer enables, active-low, always ~gnt
    logic [OW-1:0] owner;  // current owner index, 0 when not busy
    logic          busy;   // a grant is active

    modport master (
        input  req,
        output gnt,
        output g,
        output owner,
        output busy
    );

    modport slave (
        output req,
        input  gnt,
        input  g,
        input  owner,
        input  busy
    );
endinterface

// File: rtl/bus32_arb.sv
// Round-robin arbiter for the shared 32-bit tri-state bus.
// Grants one source at a time, inserts one all-off turnaround cycle between
// owners and forcibly releases a contended owner after MAX_HOLD cycles.
// Every output is a flop, so the 74x244 enables never glitch.
module bus32_arb #(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 16,
    localparam int OW       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    bus32_arb_if.master  bus
);

    // Hold counter only has to reach MAX_HOLD-1; keep at least one bit.
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX  = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
    localparam bit            FORCE_EN = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [N-1:0]  g_q,     g_d;
    logic          busy_q,  busy_d;

    logic [OW-1:0] win;
    logic          win_found;
    logic [OW-1:0] win_next;
    logic          contended;
    int            idx;

    // Round-robin pick: first requester at or after ptr, wrapping modulo N.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win       = OW'(idx);
            end
        end
        win_next = (win == OW'(N - 1)) ? '0 : win + 1'b1;
    end

    // Next-state and next-output logic for IDLE / OWN / TURN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        contended = 1'b0;

        unique case (state_q)
            IDLE, TURN: begin
                // Bus is undriven in both states, so a winner can take it directly.
                if (win_found) begin
                    state_d      = OWN;
                    owner_d      = win;
                    gnt_d        = '0;
                    gnt_d[win]   = 1'b1;
                    cnt_d        = '0;
                    ptr_d        = win_next;
                end else begin
                    state_d = IDLE;
                    owner_d = '0;
                    gnt_d   = '0;
                end
            end
            OWN: begin
                contended = |(bus.req & ~gnt_q);
                if (!bus.req[owner_q] ||
                    (FORCE_EN && (cnt_q == CNT_MAX) && contended)) begin
                    state_d = TURN;
                    owner_d = '0;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate so an uncontested owner can hold indefinitely.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase

        g_d    = ~gnt_d;
        busy_d = (state_d == OWN);
    end

    // State and output registers; reset drops every enable at once.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            g_q     <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.g     = g_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bus32_arb.sv
// Self-checking bench for bus32_arb (N=4, MAX_HOLD=4).
// A cycle-level ownership model (current owner, cycles held, rotation start)
// predicts gnt/g/owner/busy after every edge.
module tb_bus32_arb;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    bus32_arb_if #(.N(N)) bus ();

    bus32_arb #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: -1 means nobody owns the bus.
    int m_cur  = -1;
    int m_ptr  = 0;
    int m_held = 0;

    logic [N-1:0] prev_gnt = '0;
    int           owner_log[$];

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] v = '0;
        if (m_cur >= 0) v[m_cur] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge with requests r sampled.
    task automatic model_edge(input logic [N-1:0] r);
        logic [N-1:0] others;
        if (m_cur >= 0) begin
            others = r & ~m_gnt();
            if (!r[m_cur] || (m_held >= MAX_HOLD && others != '0)) begin
                m_cur = -1;
            end else begin
                m_held++;
            end
        end else if (r != '0) begin
            for (int k = 0; k < N; k++) begin
                if (m_cur < 0 && r[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
            end
            m_held = 1;
            m_ptr  = (m_cur + 1) % N;
        end
    endtask

    task automatic model_reset();
        m_cur    = -1;
        m_ptr    = 0;
        m_held   = 0;
        prev_gnt = '0;
    endtask

    task automatic check_outputs(input string ph);
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_g;
        logic [N-1:0] inv_gnt;
        exp_gnt = m_gnt();
        exp_g   = ~exp_gnt;
        inv_gnt = ~bus.gnt;
        check({ph, ".gnt"},   32'(bus.gnt),   32'(exp_gnt));
        check({ph, ".g"},     32'(bus.g),     32'(exp_g));
        check({ph, ".owner"}, 32'(bus.owner), (m_cur >= 0) ? 32'(m_cur) : 32'd0);
        check({ph, ".busy"},  32'(bus.busy),  (m_cur >= 0) ? 32'd1 : 32'd0);
        check({ph, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
        check({ph, ".g_inv"}, 32'(bus.g), 32'(inv_gnt));
        if (prev_gnt != '0 && bus.gnt != '0)
            check({ph, ".handover"}, 32'(bus.gnt), 32'(prev_gnt));
    endtask

    // Apply r, clock one edge, then compare away from the edge.
    task automatic step(input string ph, input logic [N-1:0] r);
        bus.req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_outputs(ph);
        if (bus.busy && prev_gnt == '0) owner_log.push_back(int'(bus.owner));
        prev_gnt = bus.gnt;
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge.
    task automatic do_reset(input string ph);
        #3;
        rst_n = 1'b0;
        #1;
        check({ph, ".rst_g"},     32'(bus.g),     32'hF);
        check({ph, ".rst_gnt"},   32'(bus.gnt),   32'h0);
        check({ph, ".rst_busy"},  32'(bus.busy),  32'h0);
        check({ph, ".rst_owner"}, 32'(bus.owner), 32'h0);
        model_reset();
        bus.req = 4'b1111;
        @(posedge clk);
        #1;
        check_outputs({ph, ".in_rst"});
        #2;
        rst_n   = 1'b1;
        bus.req = '0;
    endtask

    initial begin
        int cnt;
        logic [N-1:0] r;
        bus.req = '0;

        // Power-on reset, then idle with no requests.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("por.g",    32'(bus.g),    32'hF);
        check("por.busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 4'b0000);

        // Single request from source 2.
        step("single", 4'b0100);
        check("single.gnt",   32'(bus.gnt),   32'h4);
        check("single.g",     32'(bus.g),     32'hB);
        check("single.owner", 32'(bus.owner), 32'd2);
        for (int i = 0; i < 3; i++) step("single_hold", 4'b0100);
        step("single_drop", 4'b0000);
        check("single_drop.g", 32'(bus.g), 32'hF);
        step("single_idle", 4'b0000);

        // Mid-grant async reset.
        step("pre_rst", 4'b0010);
        do_reset("midgrant");

        // Rotation: all request, each owner drops its own request after one cycle.
        owner_log.delete();
        for (int i = 0; i < 9; i++) begin
            r = 4'b1111;
            if (m_cur >= 0) r[m_cur] = 1'b0;
            step("rotate", r);
        end
        check("rot.len", 32'(owner_log.size()), 32'd5);
        if (owner_log.size() == 5) begin
            check("rot.0", 32'(owner_log[0]), 32'd0);
            check("rot.1", 32'(owner_log[1]), 32'd1);
            check("rot.2", 32'(owner_log[2]), 32'd2);
            check("rot.3", 32'(owner_log[3]), 32'd3);
            check("rot.4", 32'(owner_log[4]), 32'd0);
        end

        // Forced release: source 1 holds, source 3 contends from the next edge.
        do_reset("force");
        cnt = 0;
        step("force", 4'b0010);
        if (bus.gnt == 4'b0010) cnt++;
        for (int i = 0; i < 4; i++) begin
            step("force", 4'b1010);
            if (bus.gnt == 4'b0010) cnt++;
        end
        check("force.hold_cycles", 32'(cnt), 32'd4);
        check("force.turn", 32'(bus.g), 32'hF);
        step("force_next", 4'b1010);
        check("force.new_owner", 32'(bus.gnt), 32'h8);
        step("force_hold3", 4'b1010);
        check("force.no_regrant", 32'(bus.gnt), 32'h8);
        step("force_rel3", 4'b0010);
        step("force_regrant", 4'b0010);
        check("force.regrant", 32'(bus.owner), 32'd1);

        // Uncontested hold for 20 cycles, then a contender.
        do_reset("uncont");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step("uncont", 4'b0001);
            if (bus.gnt == 4'b0001) cnt++;
        end
        check("uncont.cycles", 32'(cnt), 32'd20);
        step("uncont_contend", 4'b0101);
        check("uncont.release", 32'(bus.g), 32'hF);
        step("uncont_after", 4'b0101);
        check("uncont.owner", 32'(bus.owner), 32'd2);

        // Random contention with sticky requests and occasional resets.
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            r = r ^ N'($urandom & $urandom);
            if ($urandom_range(0, 599) == 0) do_reset("rand_rst");
            step("rand", r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
